// File: rtl/lfsr_rng_multi_if.sv
// Control and per-channel handshake bundle for the multi-channel LFSR random source.
// Latency: none; the interface carries wires only.
// Backpressure: out_ready is per channel, so a stalled consumer affects only its own channel.
interface lfsr_rng_multi_if #(
    parameter int WIDTH = 24,
    parameter int NCH   = 3,
    parameter int OUT_W = 4
);
    logic                   gen_en;
    logic                   seed_load;
    logic [WIDTH-1:0]       seed_in;
    logic [NCH-1:0]         out_ready;
    logic [NCH-1:0]         out_valid;
    logic [NCH*OUT_W-1:0]   out_data;
    logic [WIDTH-1:0]       lfsr_state;
    logic [WIDTH-1:0]       period_cnt;

    // Controller / consumer side: drives the controls and consumes digits.
    modport master (
        output gen_en, seed_load, seed_in, out_ready,
        input  out_valid, out_data, lfsr_state, period_cnt
    );

    // Generator side.
    modport slave (
        input  gen_en, seed_load, seed_in, out_ready,
        output out_valid, out_data, lfsr_state, period_cnt
    );
endinterface

// File: rtl/lfsr_rng_multi.sv
// Fibonacci LFSR feeding NCH rejection-sampled random-digit channels (values 1..MAX_VAL).
// Latency: a sampled digit and the new state appear one cycle after the advancing edge.
// Backpressure: a stalled channel holds its digit; the LFSR and other channels keep running.
module lfsr_rng_multi #(
    parameter int               WIDTH   = 24,
    parameter logic [WIDTH-1:0] TAPS    = 24'hE10000,
    parameter logic [WIDTH-1:0] SEED    = 24'h0ACE1E,
    parameter int               NCH     = 3,
    parameter int               OUT_W   = 4,
    parameter int               MAX_VAL = 9
) (
    input  logic              in_clk,
    input  logic              in_rst,
    lfsr_rng_multi_if.slave   bus
);
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0] MAX_L   = OUT_W'(MAX_VAL);

    logic [WIDTH-1:0]       state_q;
    logic [WIDTH-1:0]       cnt_q;
    logic [NCH-1:0]         vld_q;
    logic [NCH*OUT_W-1:0]   dat_q;

    logic                   advance;
    logic                   feedback;
    logic [NCH-1:0]         slot_free;
    logic [NCH-1:0]         cand_ok;

    // Seed load outranks generation; the XOR of tapped bits shifts in at the LSB.
    assign advance  = bus.gen_en & ~bus.seed_load;
    assign feedback = ^(state_q & TAPS);

    // Per-channel: slot is free if empty or being drained this edge; candidate range check.
    always_comb begin
        slot_free = '0;
        cand_ok   = '0;
        for (int c = 0; c < NCH; c++) begin
            slot_free[c] = ~vld_q[c] | bus.out_ready[c];
            cand_ok[c]   = (state_q[c*OUT_W +: OUT_W] != '0) &&
                           (state_q[c*OUT_W +: OUT_W] <= MAX_L);
        end
    end

    // LFSR state and advance counter; a zero seed would lock up, so it is replaced by SEED.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= SEED;
            cnt_q   <= '0;
        end else if (bus.seed_load) begin
            state_q <= (bus.seed_in == '0) ? SEED : bus.seed_in;
            cnt_q   <= '0;
        end else if (bus.gen_en) begin
            state_q <= {state_q[WIDTH-2:0], feedback};
            cnt_q   <= cnt_q + CNT_ONE;
        end
    end

    // Channel slots: free slots sample the pre-advance state on advance, otherwise drain.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else if (bus.seed_load) begin
            vld_q <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (slot_free[c]) begin
                    if (advance && cand_ok[c]) begin
                        vld_q[c]                 <= 1'b1;
                        dat_q[c*OUT_W +: OUT_W]  <= state_q[c*OUT_W +: OUT_W];
                    end else begin
                        vld_q[c] <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.out_valid  = vld_q;
    assign bus.out_data   = dat_q;
    assign bus.lfsr_state = state_q;
    assign bus.period_cnt = cnt_q;
endmodule

// File: tb/tb_lfsr_rng_multi.sv
// Self-checking bench for lfsr_rng_multi: default 24-bit/3-channel instance plus a 4-bit sweep instance.
// Latency: expectations are queued before each edge and compared 1 time unit after it.
// Backpressure: per-channel ready patterns are driven from the tests and mirrored in the model.
module tb_lfsr_rng_multi;
    logic clk;
    logic rst;

    lfsr_rng_multi_if #(.WIDTH(24), .NCH(3), .OUT_W(4)) b ();
    lfsr_rng_multi_if #(.WIDTH(4),  .NCH(1), .OUT_W(4)) sb ();

    lfsr_rng_multi #(
        .WIDTH(24), .TAPS(24'hE10000), .SEED(24'h0ACE1E),
        .NCH(3), .OUT_W(4), .MAX_VAL(9)
    ) dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (b)
    );

    lfsr_rng_multi #(
        .WIDTH(4), .TAPS(4'hC), .SEED(4'h1),
        .NCH(1), .OUT_W(4), .MAX_VAL(9)
    ) dut_small (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (sb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [23:0] st;
        logic [23:0] cnt;
        logic [2:0]  vld;
        logic [11:0] dat;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the default instance
    logic [23:0] m_state;
    logic [23:0] m_cnt;
    logic [2:0]  m_vld;
    logic [11:0] m_dat;

    function automatic logic [23:0] nxt24(input logic [23:0] s);
        return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
    endfunction

    function automatic logic [3:0] nxt4(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    function automatic logic [11:0] dmask(input logic [2:0] v);
        logic [11:0] m;
        m = '0;
        for (int c = 0; c < 3; c++) m[c*4 +: 4] = {4{v[c]}};
        return m;
    endfunction

    task automatic model_reset();
        m_state = 24'h0ACE1E;
        m_cnt   = '0;
        m_vld   = '0;
        m_dat   = '0;
    endtask

    // Drive one cycle on the default instance, update the model, queue the expectation.
    task automatic step(input logic g, input logic l, input logic [23:0] s, input logic [2:0] rdy);
        logic [23:0] ns;
        logic [23:0] nc;
        logic [2:0]  nv;
        logic [11:0] nd;
        logic [3:0]  cand;
        exp_t        x;
        b.gen_en    = g;
        b.seed_load = l;
        b.seed_in   = s;
        b.out_ready = rdy;
        ns = m_state; nc = m_cnt; nv = m_vld; nd = m_dat;
        if (l) begin
            ns = (s == 24'd0) ? 24'h0ACE1E : s;
            nc = '0;
            nv = '0;
        end else begin
            if (g) begin
                ns = nxt24(m_state);
                nc = m_cnt + 24'd1;
            end
            for (int c = 0; c < 3; c++) begin
                if (!m_vld[c] || rdy[c]) begin
                    cand = m_state[c*4 +: 4];
                    if (g && cand >= 4'd1 && cand <= 4'd9) begin
                        nv[c] = 1'b1;
                        nd[c*4 +: 4] = cand;
                    end else begin
                        nv[c] = 1'b0;
                    end
                end
            end
        end
        m_state = ns; m_cnt = nc; m_vld = nv; m_dat = nd;
        x.st = ns; x.cnt = nc; x.vld = nv; x.dat = nd;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // run a little so the reset lands mid-stream
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 24'd0, 3'b111);
            e = exp_q.pop_front();
            n_tests++;
            if (b.lfsr_state !== e.st || b.period_cnt !== e.cnt || b.out_valid !== e.vld ||
                ((b.out_data ^ e.dat) & dmask(e.vld)) !== 12'd0) begin
                n_fail++;
                $display("FAIL prerun[%0d]: got st=%h cnt=%0d vld=%b dat=%h want st=%h cnt=%0d vld=%b dat=%h",
                         i, b.lfsr_state, b.period_cnt, b.out_valid, b.out_data, e.st, e.cnt, e.vld, e.dat);
            end
        end
        b.gen_en = 1'b1;
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if (b.lfsr_state !== 24'h0ACE1E || b.out_valid !== 3'b000 ||
            b.out_data !== 12'd0 || b.period_cnt !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_async: got st=%h vld=%b dat=%h cnt=%0d want st=0ace1e vld=000 dat=000 cnt=0",
                     b.lfsr_state, b.out_valid, b.out_data, b.period_cnt);
        end
        n_tests++;
        if (sb.lfsr_state !== 4'h1 || sb.out_valid !== 1'b0 || sb.period_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_small: got st=%h vld=%b cnt=%0d want st=1 vld=0 cnt=0",
                     sb.lfsr_state, sb.out_valid, sb.period_cnt);
        end
        b.gen_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_one_advance();
        step(1'b1, 1'b0, 24'd0, 3'b111);
        e = exp_q.pop_front();
        n_tests++;
        if (b.lfsr_state !== 24'h159C3C || b.period_cnt !== 24'd1 || b.out_valid !== 3'b010 ||
            b.out_data[7:4] !== 4'd1 || b.lfsr_state !== e.st) begin
            n_fail++;
            $display("FAIL one_advance: got st=%h cnt=%0d vld=%b ch1=%h want st=159c3c cnt=1 vld=010 ch1=1",
                     b.lfsr_state, b.period_cnt, b.out_valid, b.out_data[7:4]);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 24'd0, 3'b101);
            e = exp_q.pop_front();
            n_tests++;
            if (b.lfsr_state !== e.st || b.period_cnt !== e.cnt || b.out_valid !== e.vld ||
                ((b.out_data ^ e.dat) & dmask(e.vld)) !== 12'd0) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: got st=%h cnt=%0d vld=%b dat=%h want st=%h cnt=%0d vld=%b dat=%h",
                         i, b.lfsr_state, b.period_cnt, b.out_valid, b.out_data, e.st, e.cnt, e.vld, e.dat);
            end
        end
        n_tests++;
        if (b.out_data[7:4] !== 4'd1 || b.out_valid[1] !== 1'b1 || b.period_cnt !== 24'd6) begin
            n_fail++;
            $display("FAIL backpressure_hold: got ch1=%h vld1=%b cnt=%0d want ch1=1 vld1=1 cnt=6",
                     b.out_data[7:4], b.out_valid[1], b.period_cnt);
        end
    endtask

    task automatic test_seed_load();
        step(1'b1, 1'b1, 24'h000000, 3'b111);
        e = exp_q.pop_front();
        n_tests++;
        if (b.lfsr_state !== 24'h0ACE1E || b.period_cnt !== 24'd0 || b.out_valid !== 3'b000 ||
            b.lfsr_state !== e.st) begin
            n_fail++;
            $display("FAIL seed_zero: got st=%h cnt=%0d vld=%b want st=0ace1e cnt=0 vld=000",
                     b.lfsr_state, b.period_cnt, b.out_valid);
        end
        step(1'b0, 1'b1, 24'h123456, 3'b111);
        e = exp_q.pop_front();
        n_tests++;
        if (b.lfsr_state !== 24'h123456 || b.period_cnt !== 24'd0) begin
            n_fail++;
            $display("FAIL seed_load: got st=%h cnt=%0d want st=123456 cnt=0", b.lfsr_state, b.period_cnt);
        end
        step(1'b1, 1'b0, 24'd0, 3'b111);
        e = exp_q.pop_front();
        n_tests++;
        if (b.lfsr_state !== 24'h2468AC || b.period_cnt !== 24'd1 || b.out_valid !== e.vld ||
            ((b.out_data ^ e.dat) & dmask(e.vld)) !== 12'd0) begin
            n_fail++;
            $display("FAIL seed_advance: got st=%h cnt=%0d vld=%b dat=%h want st=2468ac cnt=1 vld=%b dat=%h",
                     b.lfsr_state, b.period_cnt, b.out_valid, b.out_data, e.vld, e.dat);
        end
    endtask

    task automatic test_back_to_back();
        logic        g;
        logic        l;
        logic [23:0] s;
        logic [2:0]  r;
        for (int i = 0; i < 300; i++) begin
            g = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 24) == 0);
            s = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom);
            r = 3'($urandom);
            step(g, l, s, r);
            e = exp_q.pop_front();
            n_tests++;
            if (b.lfsr_state !== e.st || b.period_cnt !== e.cnt || b.out_valid !== e.vld ||
                ((b.out_data ^ e.dat) & dmask(e.vld)) !== 12'd0) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got st=%h cnt=%0d vld=%b dat=%h want st=%h cnt=%0d vld=%b dat=%h",
                         i, b.lfsr_state, b.period_cnt, b.out_valid, b.out_data, e.st, e.cnt, e.vld, e.dat);
            end
        end
        b.gen_en = 1'b0;
        b.seed_load = 1'b0;
    endtask

    task automatic test_sweep();
        logic [3:0] ms;
        logic [3:0] prev;
        exp_t       x;
        bit         early_repeat;
        bit         bad_range;
        ms = 4'h1;
        early_repeat = 1'b0;
        bad_range = 1'b0;
        for (int i = 0; i < 15; i++) begin
            prev = ms;
            ms = nxt4(ms);
            x.st  = {20'd0, ms};
            x.cnt = 24'(i + 1);
            x.vld = {2'b00, (prev >= 4'd1 && prev <= 4'd9)};
            x.dat = {8'd0, prev};
            exp_q.push_back(x);
            sb.gen_en    = 1'b1;
            sb.out_ready = 1'b1;
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if (sb.lfsr_state !== e.st[3:0] || sb.period_cnt !== e.cnt[3:0] || sb.out_valid !== e.vld[0] ||
                (e.vld[0] && sb.out_data !== e.dat[3:0])) begin
                n_fail++;
                $display("FAIL sweep[%0d]: got st=%h cnt=%0d vld=%b dat=%h want st=%h cnt=%0d vld=%b dat=%h",
                         i, sb.lfsr_state, sb.period_cnt, sb.out_valid, sb.out_data,
                         e.st[3:0], e.cnt[3:0], e.vld[0], e.dat[3:0]);
            end
            if (i < 14 && sb.lfsr_state === 4'h1) early_repeat = 1'b1;
            if (sb.out_valid === 1'b1 && (sb.out_data < 4'd1 || sb.out_data > 4'd9)) bad_range = 1'b1;
        end
        sb.gen_en = 1'b0;
        n_tests++;
        if (sb.lfsr_state !== 4'h1 || early_repeat || sb.period_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL sweep_period: got st=%h early_repeat=%0d cnt=%0d want st=1 early_repeat=0 cnt=15",
                     sb.lfsr_state, early_repeat, sb.period_cnt);
        end
        n_tests++;
        if (bad_range !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_range: got out-of-range valid=%0d want 0", bad_range);
        end
    endtask

    initial begin
        rst = 1'b1;
        b.gen_en = 1'b0;  b.seed_load = 1'b0;  b.seed_in = '0;  b.out_ready = '0;
        sb.gen_en = 1'b0; sb.seed_load = 1'b0; sb.seed_in = '0; sb.out_ready = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_one_advance();
        test_backpressure();
        test_seed_load();
        test_back_to_back();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
